// File: rtl/nn_seq_pkg.sv
// rtl/nn_seq_pkg.sv - shared types and sizing helpers for the layer sequencer
package nn_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        REQ_BIAS,
        REQ_W,
        LOAD_X,
        WAIT_ALU,
        ACC,
        WRITE,
        DONE
    } seq_state_t;

    typedef enum logic {
        LAYER_1 = 1'b0,
        LAYER_2 = 1'b1
    } layer_t;

    // Total weight-memory words: per neuron one bias word plus one word per input group.
    function automatic int word_count(input int lanes, input int in_groups,
                                      input int hid, input int outn);
        return hid * (1 + in_groups) + outn * (1 + hid / lanes);
    endfunction

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - clearable up-counter used for group and neuron indices
module flex_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         count_enable,
    output logic [W-1:0] count
);

    // Clear has priority over increment so a restart never sees a stale index.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// rtl/nn_layer_sequencer.sv - two-layer MAC sequencer driving weight fetch, inputs and ALU strobes
module nn_layer_sequencer
    import nn_seq_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int DW        = 4,
    parameter int IN_GROUPS = 2,
    parameter int HID       = 8,
    parameter int OUT       = 10,
    parameter int ALU_LAT   = 3,
    parameter int MEM_AW    = 16
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        mem_req,
    output logic [MEM_AW-1:0]           mem_addr,
    input  logic                        mem_valid,
    input  logic [LANES*DW-1:0]         mem_data,
    output logic                        pix_shift,
    input  logic [LANES*DW-1:0]         pix_data,
    output logic [$clog2(HID+OUT)-1:0]  act_raddr,
    input  logic [DW-1:0]               act_rdata,
    output logic                        act_we,
    output logic [$clog2(HID+OUT)-1:0]  act_waddr,
    output logic [DW-1:0]               act_wdata,
    output logic                        alu_clear,
    output logic                        alu_acc,
    output logic [LANES*DW-1:0]         alu_w,
    output logic [LANES*DW-1:0]         alu_x,
    output logic [DW-1:0]               alu_bias,
    input  logic [DW-1:0]               alu_result
);

    localparam int AAW   = $clog2(HID + OUT);
    localparam int G2    = HID / LANES;
    localparam int NW    = $clog2((HID > OUT ? HID : OUT) + 1);
    localparam int GW    = $clog2((IN_GROUPS > G2 ? IN_GROUPS : G2) + 1);
    localparam int SW    = $clog2(LANES + ALU_LAT + 2);
    localparam int WORDS = word_count(LANES, IN_GROUPS, HID, OUT);

    if (HID % LANES != 0) begin : g_hid_check
        $error("HID must be a multiple of LANES");
    end
    if (longint'(WORDS) > (longint'(1) << MEM_AW)) begin : g_aw_check
        $error("weight memory does not fit in MEM_AW address bits");
    end

    seq_state_t        state, state_nx;
    layer_t            layer;
    logic              tail;
    logic [SW-1:0]     step;
    logic [MEM_AW-1:0] addr;
    logic [GW-1:0]     group;
    logic [NW-1:0]     neuron;
    logic              grp_clr, grp_inc, nrn_clr, nrn_inc;
    logic              group_last, neuron_last;

    assign mem_addr    = addr;
    assign group_last  = int'(group) == ((layer == LAYER_1) ? IN_GROUPS : G2) - 1;
    assign neuron_last = int'(neuron) == ((layer == LAYER_1) ? HID : OUT) - 1;

    flex_counter #(.W(GW)) u_group (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (grp_clr),
        .count_enable (grp_inc),
        .count        (group)
    );

    flex_counter #(.W(NW)) u_neuron (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (nrn_clr),
        .count_enable (nrn_inc),
        .count        (neuron)
    );

    // Control registers: state, per-state step timer, layer flag, post-accumulate tail flag, word address.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            layer <= LAYER_1;
            tail  <= 1'b0;
            step  <= '0;
            addr  <= '0;
        end else begin
            state <= state_nx;
            step  <= (state_nx != state) ? '0 : step + 1'b1;
            if (state == IDLE && start) begin
                addr <= '0;
            end else if (mem_req && mem_valid) begin
                addr <= addr + 1'b1;
            end
            if (state == IDLE && start) begin
                layer <= LAYER_1;
            end else if (state == WRITE && neuron_last) begin
                layer <= LAYER_2;
            end
            if (state == ACC) begin
                tail <= group_last;
            end else if (state == LOAD_X) begin
                tail <= 1'b0;
            end
        end
    end

    // Operand registers: bias and weights from memory, inputs from pixels (layer 1) or activations (layer 2).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            alu_bias <= '0;
            alu_w    <= '0;
            alu_x    <= '0;
        end else begin
            if (state == REQ_BIAS && mem_valid) begin
                alu_bias <= mem_data[DW-1:0];
            end
            if (state == REQ_W && mem_valid) begin
                alu_w <= mem_data;
            end
            if (state == LOAD_X) begin
                if (layer == LAYER_1) begin
                    alu_x <= pix_data;
                end else if (int'(step) >= 1) begin
                    alu_x[(int'(step) - 1) * DW +: DW] <= act_rdata;
                end
            end
        end
    end

    // Next-state and strobe decode; every output defaults low so IDLE drives an all-zero bus.
    always_comb begin
        state_nx  = state;
        grp_clr   = 1'b0;
        grp_inc   = 1'b0;
        nrn_clr   = 1'b0;
        nrn_inc   = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        mem_req   = 1'b0;
        pix_shift = 1'b0;
        alu_clear = 1'b0;
        alu_acc   = 1'b0;
        act_we    = 1'b0;
        act_wdata = '0;
        act_waddr = '0;
        act_raddr = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CLEAR;
                    grp_clr  = 1'b1;
                    nrn_clr  = 1'b1;
                end
            end
            CLEAR: begin
                alu_clear = 1'b1;
                state_nx  = REQ_BIAS;
            end
            REQ_BIAS: begin
                mem_req = 1'b1;
                if (mem_valid) state_nx = REQ_W;
            end
            REQ_W: begin
                mem_req = 1'b1;
                if (mem_valid) state_nx = LOAD_X;
            end
            LOAD_X: begin
                if (layer == LAYER_1) begin
                    pix_shift = 1'b1;
                    state_nx  = WAIT_ALU;
                end else begin
                    if (int'(step) < LANES) begin
                        act_raddr = AAW'(int'(group) * LANES + int'(step));
                    end
                    if (int'(step) == LANES) state_nx = WAIT_ALU;
                end
            end
            WAIT_ALU: begin
                if (int'(step) == ALU_LAT - 1) state_nx = tail ? WRITE : ACC;
            end
            ACC: begin
                alu_acc = 1'b1;
                if (group_last) begin
                    state_nx = WAIT_ALU;
                end else begin
                    grp_inc  = 1'b1;
                    state_nx = REQ_W;
                end
            end
            WRITE: begin
                act_we    = 1'b1;
                act_wdata = alu_result;
                act_waddr = (layer == LAYER_1) ? AAW'(neuron) : AAW'(HID + int'(neuron));
                grp_clr   = 1'b1;
                if (!neuron_last) begin
                    nrn_inc  = 1'b1;
                    state_nx = CLEAR;
                end else if (layer == LAYER_1) begin
                    nrn_clr  = 1'b1;
                    state_nx = CLEAR;
                end else begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb/tb_nn_layer_sequencer.sv - randomized self-checking bench with behavioural inference model
module tb_nn_layer_sequencer;

    localparam int LANES = 4, DW = 4, IN_GROUPS = 2, HID = 8, OUT = 10, ALU_LAT = 3, MEM_AW = 16;
    localparam int AAW = $clog2(HID + OUT);
    localparam int NN = HID + OUT;
    localparam int NWORDS = 8 * 3 + 10 * 3;
    localparam int BUDGET = 20000;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic start = 1'b0;
    logic busy, done, mem_req, pix_shift, act_we, alu_clear, alu_acc;
    logic [MEM_AW-1:0] mem_addr;
    logic mem_valid = 1'b0;
    logic [LANES*DW-1:0] mem_data = '0;
    logic [LANES*DW-1:0] pix_data = '0;
    logic [AAW-1:0] act_raddr, act_waddr;
    logic [DW-1:0] act_rdata = '0;
    logic [DW-1:0] act_wdata, alu_bias;
    logic [LANES*DW-1:0] alu_w, alu_x;
    logic [DW-1:0] alu_result = '0;

    always #5 clk = ~clk;

    nn_layer_sequencer #(
        .LANES(LANES), .DW(DW), .IN_GROUPS(IN_GROUPS), .HID(HID),
        .OUT(OUT), .ALU_LAT(ALU_LAT), .MEM_AW(MEM_AW)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .busy(busy), .done(done),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
        .pix_shift(pix_shift), .pix_data(pix_data), .act_raddr(act_raddr), .act_rdata(act_rdata),
        .act_we(act_we), .act_waddr(act_waddr), .act_wdata(act_wdata), .alu_clear(alu_clear),
        .alu_acc(alu_acc), .alu_w(alu_w), .alu_x(alu_x), .alu_bias(alu_bias), .alu_result(alu_result)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // environment images and configuration (written only by the main initial block)
    logic [LANES*DW-1:0] mem_img [NWORDS];
    logic [LANES*DW-1:0] pix_img [IN_GROUPS];
    int fixed_delay = 0;
    bit rand_delay = 0;
    bit spur = 0;
    bit addr1 = 0;

    // environment state owned by the responder
    int mwait = 0, cur_delay = 0, pix_idx = 0;
    bit real_valid = 0;

    // model / monitor state owned by the negedge process
    logic [DW-1:0] act_ram [NN];
    logic [DW-1:0] hid_model [HID];
    int exp_addr = 0, acc_n = 0, acc_g = 0;
    int words = 0, pixes = 0, writes = 0, dones = 0;
    int acc_log [$];
    bit prev_req = 0, prev_acc = 0, prev_done = 0, pix_pend = 0;
    logic [MEM_AW-1:0] prev_addr = '0;
    logic [AAW-1:0] rd_addr_s = '0;
    logic [LANES*DW-1:0] n8g1 = '0;

    function automatic int groups_of(input int n);
        return (n < HID) ? IN_GROUPS : HID / LANES;
    endfunction

    function automatic int base_of(input int n);
        return (n < HID) ? n * (1 + IN_GROUPS) : HID * (1 + IN_GROUPS) + (n - HID) * (1 + HID / LANES);
    endfunction

    function automatic logic [LANES*DW-1:0] exp_x(input int n, input int g);
        logic [LANES*DW-1:0] r;
        r = '0;
        if (n < HID) begin
            r = pix_img[g];
        end else begin
            for (int k = 0; k < LANES; k++) begin
                r[k*DW +: DW] = addr1 ? DW'(g * LANES + k + 1) : hid_model[g * LANES + k];
            end
        end
        return r;
    endfunction

    // Environment: memory with programmable latency and spurious valids, pixel source, activation RAM, ALU result.
    always @(posedge clk) begin
        #1;
        if (!n_rst) begin
            mem_valid = 1'b0;
            mwait = 0;
            real_valid = 0;
            pix_idx = 0;
            act_rdata = '0;
        end else begin
            if (pix_pend) pix_idx++;
            if (addr1) act_rdata = DW'(int'(rd_addr_s) + 1);
            else act_rdata = (int'(rd_addr_s) < NN) ? act_ram[rd_addr_s] : '0;
            if (real_valid) begin
                mwait = 0;
                cur_delay = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
            end
            real_valid = 0;
            mem_valid = 1'b0;
            if (mem_req) begin
                if (mwait >= cur_delay) begin
                    mem_valid = 1'b1;
                    real_valid = 1;
                    mem_data = (int'(mem_addr) < NWORDS) ? mem_img[mem_addr] : '0;
                end else begin
                    mwait++;
                end
            end else if (spur && $urandom_range(0, 2) == 0) begin
                mem_valid = 1'b1;
                mem_data = 16'($urandom);
            end
        end
        pix_data = pix_img[pix_idx % IN_GROUPS];
        alu_result = 4'($urandom);
    end

    // Compare process: checks every meaningful DUT output against the inference model each cycle.
    always @(negedge clk) begin
        if (!n_rst) begin
            exp_addr = 0; acc_n = 0; acc_g = 0;
            prev_req = 0; prev_acc = 0; prev_done = 0; pix_pend = 0;
            rd_addr_s = '0;
        end else begin
            logic [LANES*DW-1:0] bw;
            int b;
            if (prev_done) chk(busy == 1'b0, "busy_fall", busy, 0);
            prev_done = done;
            if (mem_req && prev_req && !prev_acc) chk(mem_addr == prev_addr, "addr_hold", mem_addr, prev_addr);
            prev_req = mem_req;
            prev_acc = mem_req && mem_valid;
            prev_addr = mem_addr;
            if (mem_req && mem_valid) begin
                chk(int'(mem_addr) == exp_addr, "mem_addr", mem_addr, exp_addr);
                acc_log.push_back(int'(mem_addr));
                words++;
                exp_addr++;
            end
            pix_pend = pix_shift;
            if (pix_shift) pixes++;
            rd_addr_s = act_raddr;
            if (alu_acc) begin
                if (acc_n >= NN || acc_g >= groups_of(acc_n)) begin
                    chk(1'b0, "acc_extra", acc_g, groups_of(acc_n));
                end else begin
                    b = base_of(acc_n);
                    bw = mem_img[b];
                    chk(alu_bias == bw[DW-1:0], "alu_bias", alu_bias, bw[DW-1:0]);
                    chk(alu_w == mem_img[b + 1 + acc_g], "alu_w", alu_w, mem_img[b + 1 + acc_g]);
                    chk(alu_x == exp_x(acc_n, acc_g), "alu_x", alu_x, exp_x(acc_n, acc_g));
                    if (addr1 && acc_n == HID && acc_g == 1) n8g1 = alu_x;
                    acc_g++;
                end
            end
            if (act_we) begin
                chk(int'(act_waddr) == acc_n, "act_waddr", act_waddr, acc_n);
                chk(act_wdata == alu_result, "act_wdata", act_wdata, alu_result);
                chk(acc_g == groups_of(acc_n), "acc_count", acc_g, groups_of(acc_n));
                if (acc_n < HID) hid_model[acc_n] = alu_result;
                if (int'(act_waddr) < NN) act_ram[act_waddr] = act_wdata;
                writes++;
                acc_n++;
                acc_g = 0;
            end
            if (done) begin
                dones++;
                chk(acc_n == NN, "writes_at_done", acc_n, NN);
                acc_n = 0; acc_g = 0; exp_addr = 0;
            end
        end
    end

    task automatic wait_done(input string tag);
        bit got;
        got = 0;
        for (int c = 0; c < BUDGET && !got; c++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        chk(got, {tag, "_timeout"}, got, 1);
    endtask

    task automatic run_one(input string tag);
        int w0, p0, wr0, d0;
        w0 = words; p0 = pixes; wr0 = writes; d0 = dones;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(tag);
        repeat (3) @(negedge clk);
        chk(words - w0 == NWORDS, {tag, "_words"}, words - w0, NWORDS);
        chk(pixes - p0 == 16, {tag, "_pix"}, pixes - p0, 16);
        chk(writes - wr0 == 18, {tag, "_writes"}, writes - wr0, 18);
        chk(dones - d0 == 1, {tag, "_dones"}, dones - d0, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({busy, done, mem_req, pix_shift, act_we, alu_clear, alu_acc} == 7'd0, {tag, "_strobes"},
            {busy, done, mem_req, pix_shift, act_we, alu_clear, alu_acc}, 0);
        chk(mem_addr == '0, {tag, "_mem_addr"}, mem_addr, 0);
        chk(alu_w == '0 && alu_x == '0 && alu_bias == '0, {tag, "_alu_bus"}, {alu_w, alu_x, alu_bias}, 0);
        chk(act_raddr == '0 && act_waddr == '0 && act_wdata == '0, {tag, "_act_bus"},
            {act_raddr, act_waddr, act_wdata}, 0);
    endtask

    initial begin
        int idx, d0;
        bit hit;
        for (int i = 0; i < NWORDS; i++) mem_img[i] = 16'($urandom);
        for (int i = 0; i < IN_GROUPS; i++) pix_img[i] = 16'($urandom);
        for (int i = 0; i < NN; i++) act_ram[i] = '0;

        repeat (3) @(negedge clk);
        chk_zero("reset");
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        run_one("zero_wait");

        fixed_delay = 5;
        spur = 1;
        run_one("delay5");

        rand_delay = 1;
        addr1 = 1;
        run_one("addr1");
        chk(n8g1 == 16'h8765, "n8g1_lanes", n8g1, 16'h8765);

        rand_delay = 0;
        fixed_delay = 0;
        spur = 0;
        addr1 = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        for (int c = 0; c < BUDGET && !hit; c++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 16'd20) hit = 1;
        end
        chk(hit, "reach_addr20", hit, 1);
        d0 = dones;
        #2 n_rst = 1'b0;
        #1 chk_zero("async_rst");
        repeat (5) @(negedge clk);
        chk(dones == d0, "no_done_after_rst", dones - d0, 0);
        n_rst = 1'b1;
        idx = acc_log.size();
        run_one("restart");
        chk(acc_log.size() > idx && acc_log[idx] == 0, "restart_addr0",
            (acc_log.size() > idx) ? acc_log[idx] : -1, 0);

        idx = words;
        d0 = dones;
        @(negedge clk);
        start = 1'b1;
        wait_done("held1");
        @(negedge clk);
        chk(busy == 1'b0, "held_idle_gap", busy, 0);
        @(negedge clk);
        chk(busy == 1'b1, "held_restart", busy, 1);
        wait_done("held2");
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk(dones - d0 == 2, "held_dones", dones - d0, 2);
        chk(words - idx == 2 * NWORDS, "held_words", words - idx, 2 * NWORDS);
        chk(busy == 1'b0, "held_stops", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
